// File: rtl/vga_fb1bpp_scanout_if.sv
// Framebuffer BRAM read port used by the VGA scanout engine.
// The master issues a one-cycle request; the slave returns data on the next cycle.
interface vga_fb1bpp_scanout_if #(
  parameter int unsigned ADDRBITS = 13
);
  logic                vga_req;
  logic [ADDRBITS-1:0] vga_adr;
  logic [7:0]          vga_dat;

  modport master (output vga_req, output vga_adr, input  vga_dat);
  modport slave  (input  vga_req, input  vga_adr, output vga_dat);
endinterface

// File: rtl/vga_fb1bpp_scanout.sv
// 640x480@60 scanout of a 320x200 1bpp framebuffer, pixel-doubled to 640x400.
// Optional vblank pulse: define VGA_VBLANK_IRQ_EN.
module vga_fb1bpp_scanout #(
  parameter int unsigned ADDRBITS = 13,
  parameter int unsigned FB_BASE  = 0,
  parameter logic [2:0]  FG_COLOR = 3'b111,
  parameter logic [2:0]  BG_COLOR = 3'b000
) (
  input  logic                        I_clk,
  input  logic                        I_reset_n,
  vga_fb1bpp_scanout_if.master        bram,
  output logic                        O_hsync,
  output logic                        O_vsync,
  output logic [2:0]                  O_rgb,
  output logic                        O_vblank_irq
);

  localparam int unsigned HW  = 10;
  localparam int unsigned VW  = 10;
  localparam int unsigned RBW = 13;

  logic [HW-1:0]       h_q, h_d;
  logic [VW-1:0]       v_q, v_d;
  logic [RBW-1:0]      row_base_q, row_base_d;
  logic                req_q, req_d;
  logic [ADDRBITS-1:0] adr_q, adr_d;
  logic                fill_q;
  logic [7:0]          pf_q, pf_d;
  logic [7:0]          sh_q, sh_d;
  logic                hsync_q, hsync_d;
  logic                vsync_q, vsync_d;
  logic [2:0]          rgb_q, rgb_d;

  logic                wrap_fetch_c, line_fetch_c, pix_c;
  logic [5:0]          k_c;
  logic [RBW-1:0]      next_base_c;
  logic [7:0]          byte_c;

  // Counters, fetch scheduling and pixel generation
  always_comb begin
    h_d        = h_q + 10'd1;
    v_d        = v_q;
    row_base_d = row_base_q;
    if (h_q == 10'd799) begin
      h_d = '0;
      if (v_q == 10'd524) begin
        v_d        = '0;
        row_base_d = '0;
      end else begin
        v_d = v_q + 10'd1;
        if (v_q[0] && (v_q <= 10'd397)) row_base_d = row_base_q + 13'd40;
      end
    end

    // Requests are decoded from the next counter state so req lands on h=16k-2
    wrap_fetch_c = (h_d == 10'd798) && ((v_d <= 10'd398) || (v_d == 10'd524));
    line_fetch_c = (v_d < 10'd400) && (h_d >= 10'd14) && (h_d <= 10'd622) &&
                   (h_d[3:0] == 4'd14);
    k_c          = 6'((h_d + 10'd2) >> 4);
    next_base_c  = (v_d == 10'd524) ? '0 :
                   (v_d[0] ? (row_base_q + 13'd40) : row_base_q);

    req_d = wrap_fetch_c || line_fetch_c;
    adr_d = adr_q;
    if (wrap_fetch_c) begin
      adr_d = ADDRBITS'(FB_BASE) + ADDRBITS'(next_base_c);
    end else if (line_fetch_c) begin
      adr_d = ADDRBITS'(FB_BASE) + ADDRBITS'(row_base_q) + ADDRBITS'(k_c);
    end

    pf_d = fill_q ? bram.vga_dat : pf_q;
    sh_d = (h_q[3:0] == 4'd0) ? pf_q : sh_q;

    // On the byte boundary the shift register is being loaded this cycle
    byte_c  = (h_q[3:0] == 4'd0) ? pf_q : sh_q;
    pix_c   = byte_c[3'd7 - h_q[3:1]];
    rgb_d   = ((h_q < 10'd640) && (v_q < 10'd400)) ? (pix_c ? FG_COLOR : BG_COLOR) : 3'b000;
    hsync_d = !((h_q >= 10'd656) && (h_q <= 10'd751));
    vsync_d = !((v_q >= 10'd490) && (v_q <= 10'd491));
  end

  // State and registered outputs; reset lands in vblank so line 0 gets prefetched
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      h_q        <= '0;
      v_q        <= 10'd480;
      row_base_q <= '0;
      req_q      <= 1'b0;
      adr_q      <= '0;
      fill_q     <= 1'b0;
      pf_q       <= '0;
      sh_q       <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      rgb_q      <= 3'b000;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      row_base_q <= row_base_d;
      req_q      <= req_d;
      adr_q      <= adr_d;
      fill_q     <= req_q;
      pf_q       <= pf_d;
      sh_q       <= sh_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      rgb_q      <= rgb_d;
    end
  end

`ifdef VGA_VBLANK_IRQ_EN
  logic irq_q;

  // One pulse per frame at the first vblank line
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) irq_q <= 1'b0;
    else            irq_q <= (h_q == 10'd0) && (v_q == 10'd400);
  end

  assign O_vblank_irq = irq_q;
`else
  assign O_vblank_irq = 1'b0;
`endif

  assign bram.vga_req = req_q;
  assign bram.vga_adr = adr_q;
  assign O_hsync      = hsync_q;
  assign O_vsync      = vsync_q;
  assign O_rgb        = rgb_q;

endmodule
